// File: rtl/seg_scan_rx.sv
// Receive side of the 8-digit multiplexed seven-segment bus: settles, decodes and frames the scanned digits.
// Latency: digit accepted STABLE_CYC samples after it appears; FRAME_VALID 1 cycle after the 8th digit's accept.
// Backpressure: none; the bus is observed passively and every output is a level or a one-cycle pulse.
module seg_scan_rx #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned TO_W       = 20
) (
  input  logic        CLK,
  input  logic        N_Reset,
  input  logic [7:0]  SEG_COM,
  input  logic [7:0]  SEG_DATA,
  output logic [31:0] DIGITS,
  output logic [7:0]  BLANK,
  output logic [7:0]  DP,
  output logic        FRAME_VALID,
  output logic        SEG_ERR,
  output logic        STALE
);

  localparam logic [7:0]      STABLE_V = 8'(STABLE_CYC);
  localparam logic [7:0]      STABLE_M1 = 8'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_V     = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      com_q, data_q, com_p_q, data_p_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      seen_q, seen_d;
  logic [31:0]     wval_q, wval_d;
  logic [7:0]      wblank_q, wblank_d;
  logic [7:0]      wdp_q, wdp_d;
  logic [31:0]     digits_q, digits_d;
  logic [7:0]      blank_q, blank_d;
  logic [7:0]      dp_q, dp_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;
  logic [TO_W-1:0] to_q, to_d;

  logic            same, acc, com_blank, com_one;
  logic [7:0]      com_inv;
  logic [2:0]      dig_idx;
  logic [5:0]      dec;

  // Segment pattern {A..G} to {legal, blank, value}.
  function automatic logic [5:0] seg_dec(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b1111110: r = {2'b10, 4'h0};
      7'b0110000: r = {2'b10, 4'h1};
      7'b1101101: r = {2'b10, 4'h2};
      7'b1111001: r = {2'b10, 4'h3};
      7'b0110011: r = {2'b10, 4'h4};
      7'b1011011: r = {2'b10, 4'h5};
      7'b1011111: r = {2'b10, 4'h6};
      7'b1110000: r = {2'b10, 4'h7};
      7'b1111111: r = {2'b10, 4'h8};
      7'b1111011: r = {2'b10, 4'h9};
      7'b1110111: r = {2'b10, 4'hA};
      7'b0011111: r = {2'b10, 4'hB};
      7'b1001110: r = {2'b10, 4'hC};
      7'b0111101: r = {2'b10, 4'hD};
      7'b1001111: r = {2'b10, 4'hE};
      7'b1000111: r = {2'b10, 4'hF};
      7'b0000000: r = {2'b11, 4'h0};
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  // Stability tracking: count consecutive identical registered samples, accept once on reaching STABLE_CYC.
  always_comb begin
    same  = ({com_q, data_q} == {com_p_q, data_p_q});
    acc   = same && (cnt_q == STABLE_M1);
    cnt_d = 8'd1;
    if (same) begin
      cnt_d = (cnt_q == STABLE_V) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Classify the select lines and find the single low bit when there is one.
  always_comb begin
    com_blank = (com_q == 8'hFF);
    com_inv   = ~com_q;
    com_one   = (com_inv != 8'h00) && ((com_inv & (com_inv - 8'd1)) == 8'h00);
    dig_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!com_q[k]) dig_idx = 3'(k);
    end
    dec = seg_dec(data_q[7:1]);
  end

  // Frame assembly, error handling, timeout and the collect/publish state machine.
  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    wval_d   = wval_q;
    wblank_d = wblank_q;
    wdp_d    = wdp_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    dp_d     = dp_q;
    err_d    = 1'b0;
    stale_d  = stale_q;
    to_d     = (to_q != TO_V) ? to_q + TO_ONE : to_q;

    // The publish cycle clears the mask first so a same-cycle accept lands in the next frame.
    if (state_q == S_PUBLISH) begin
      seen_d  = 8'h00;
      state_d = S_COLLECT;
    end

    if (acc && !com_blank) begin
      if (com_one && dec[5]) begin
        wval_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
        wblank_d[dig_idx]             = dec[4];
        wdp_d[dig_idx]                = data_q[0];
        seen_d[dig_idx]               = 1'b1;
        to_d                          = '0;
        if (state_d == S_IDLE) state_d = S_COLLECT;
        if (seen_d == 8'hFF) begin
          // Outputs load on entry to PUBLISH so they are valid alongside FRAME_VALID.
          digits_d = wval_d;
          blank_d  = wblank_d;
          dp_d     = wdp_d;
          stale_d  = 1'b0;
          state_d  = S_PUBLISH;
        end
      end else begin
        err_d   = 1'b1;
        seen_d  = 8'h00;
        state_d = S_IDLE;
      end
    end

    // Timeout fires once when the counter reaches TIMEOUT; a valid accept that cycle cleared it already.
    if ((to_q == TO_LAST) && (to_d != '0)) begin
      stale_d = 1'b1;
      seen_d  = 8'h00;
      state_d = S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge N_Reset) begin
    if (!N_Reset) begin
      state_q  <= S_IDLE;
      com_q    <= 8'hFF;
      data_q   <= 8'h00;
      com_p_q  <= 8'hFF;
      data_p_q <= 8'h00;
      cnt_q    <= 8'd0;
      seen_q   <= 8'h00;
      wval_q   <= 32'h0;
      wblank_q <= 8'h00;
      wdp_q    <= 8'h00;
      digits_q <= 32'h0;
      blank_q  <= 8'hFF;
      dp_q     <= 8'h00;
      err_q    <= 1'b0;
      stale_q  <= 1'b1;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      com_q    <= SEG_COM;
      data_q   <= SEG_DATA;
      com_p_q  <= com_q;
      data_p_q <= data_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      wval_q   <= wval_d;
      wblank_q <= wblank_d;
      wdp_q    <= wdp_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
      to_q     <= to_d;
    end
  end

  assign DIGITS      = digits_q;
  assign BLANK       = blank_q;
  assign DP          = dp_q;
  assign FRAME_VALID = (state_q == S_PUBLISH);
  assign SEG_ERR     = err_q;
  assign STALE       = stale_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: directed scans plus randomized frames against a slot-level reference model.
// Model reasons per held bus value (hold length vs STABLE), not per cycle.
// Pulses are logged by a monitor and compared against the model's predicted edge and payload.
module tb_seg_scan_rx;
  localparam int STABLE = 4;
  localparam int TMO    = 100;

  logic        CLK = 1'b0;
  logic        N_Reset;
  logic [7:0]  SEG_COM, SEG_DATA;
  logic [31:0] DIGITS;
  logic [7:0]  BLANK, DP;
  logic        FRAME_VALID, SEG_ERR, STALE;

  seg_scan_rx #(.STABLE_CYC(STABLE), .TIMEOUT(TMO), .TO_W(8)) dut (
    .CLK(CLK), .N_Reset(N_Reset), .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA),
    .DIGITS(DIGITS), .BLANK(BLANK), .DP(DP),
    .FRAME_VALID(FRAME_VALID), .SEG_ERR(SEG_ERR), .STALE(STALE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          e;
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  p;
  } frame_t;

  int     edge_cnt = 0;
  int     checks   = 0;
  int     failures = 0;
  frame_t fv_act[$], fv_exp[$];
  int     err_act[$], err_exp[$];

  logic [6:0] seg_tab [16];

  // reference model state
  logic [3:0]  m_wval [8];
  logic [7:0]  m_wblank, m_wdp, m_seen;
  logic [31:0] m_pub_d;
  logic [7:0]  m_pub_b, m_pub_p;
  bit          m_stale, m_tout;
  int          m_last;

  always @(posedge CLK) edge_cnt++;

  always @(negedge CLK) begin
    if (FRAME_VALID === 1'b1) fv_act.push_back('{e: edge_cnt, d: DIGITS, b: BLANK, p: DP});
    if (SEG_ERR === 1'b1) err_act.push_back(edge_cnt);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int v, input bit dp, input bit blank);
    logic [6:0] s;
    s = blank ? 7'b0 : seg_tab[v];
    return {s, dp};
  endfunction

  task automatic model_reset();
    m_seen = 8'h00; m_wblank = 8'h00; m_wdp = 8'h00;
    for (int i = 0; i < 8; i++) m_wval[i] = 4'h0;
    m_pub_d = 32'h0; m_pub_b = 8'hFF; m_pub_p = 8'h00;
    m_stale = 1'b1; m_tout = 1'b0;
  endtask

  task automatic model_tick(input int upto);
    if (!m_tout && upto >= m_last + TMO) begin
      m_tout  = 1'b1;
      m_stale = 1'b1;
      m_seen  = 8'h00;
    end
  endtask

  // One held bus value of n samples whose first sample is taken at edge fe.
  task automatic model_slot(input logic [7:0] c, input logic [7:0] d, input int n, input int fe);
    int ea, zeros, k, v;
    bit bl;
    if (n < STABLE || c == 8'hFF) return;
    ea = fe + STABLE;
    zeros = 0; k = 0; v = -1; bl = 1'b0;
    for (int i = 0; i < 8; i++) if (!c[i]) begin zeros++; k = i; end
    if (d[7:1] == 7'b0) begin v = 0; bl = 1'b1; end
    else for (int i = 0; i < 16; i++) if (seg_tab[i] == d[7:1]) v = i;
    if (zeros != 1 || v < 0) begin
      model_tick(ea);
      err_exp.push_back(ea);
      m_seen = 8'h00;
      return;
    end
    model_tick(ea - 1);
    m_wval[k] = v[3:0]; m_wblank[k] = bl; m_wdp[k] = d[0]; m_seen[k] = 1'b1;
    m_last = ea; m_tout = 1'b0;
    if (m_seen == 8'hFF) begin
      for (int i = 0; i < 8; i++) m_pub_d[4*i +: 4] = m_wval[i];
      m_pub_b = m_wblank; m_pub_p = m_wdp;
      m_stale = 1'b0; m_seen = 8'h00;
      fv_exp.push_back('{e: ea, d: m_pub_d, b: m_pub_b, p: m_pub_p});
    end
  endtask

  // Called right after a negedge; drives one bus value for n cycles.
  task automatic slot(input logic [7:0] c, input logic [7:0] d, input int n);
    SEG_COM = c; SEG_DATA = d;
    model_slot(c, d, n, edge_cnt + 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic scan_digit(input int k, input int v, input bit dp, input bit bl, input int hold, input int glen);
    logic [7:0] c, gc;
    c  = ~(8'h01 << k);
    gc = c ^ (8'h01 << $urandom_range(0, 7));
    if (glen > 0) slot(gc, 8'($urandom), glen);
    slot(c, enc(v, dp, bl), hold);
  endtask

  task automatic rand_scan(input int nd);
    int ord[8];
    int j, t;
    for (int i = 0; i < 8; i++) ord[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < nd; i++) begin
      if (i == 7 && nd == 8 && $urandom_range(0, 1) == 1)
        scan_digit(ord[0], $urandom_range(0, 15), 1'($urandom), 1'b0, STABLE, 0);
      scan_digit(ord[i], $urandom_range(0, 15), 1'($urandom), ($urandom_range(0, 3) == 0),
                 $urandom_range(STABLE, 12), $urandom_range(0, STABLE - 1));
    end
  endtask

  task automatic tail();
    slot(8'hFF, 8'h00, 6);
  endtask

  task automatic check_all(input string tag);
    int n;
    model_tick(edge_cnt);
    chk({tag, ".fv_count"}, 32'(fv_act.size()), 32'(fv_exp.size()));
    n = (fv_act.size() < fv_exp.size()) ? fv_act.size() : fv_exp.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".fv_edge"}, 32'(fv_act[i].e), 32'(fv_exp[i].e));
      chk({tag, ".fv_digits"}, fv_act[i].d, fv_exp[i].d);
      chk({tag, ".fv_blank"}, 32'(fv_act[i].b), 32'(fv_exp[i].b));
      chk({tag, ".fv_dp"}, 32'(fv_act[i].p), 32'(fv_exp[i].p));
    end
    chk({tag, ".err_count"}, 32'(err_act.size()), 32'(err_exp.size()));
    n = (err_act.size() < err_exp.size()) ? err_act.size() : err_exp.size();
    for (int i = 0; i < n; i++) chk({tag, ".err_edge"}, 32'(err_act[i]), 32'(err_exp[i]));
    chk({tag, ".digits"}, DIGITS, m_pub_d);
    chk({tag, ".blank"}, 32'(BLANK), 32'(m_pub_b));
    chk({tag, ".dp"}, 32'(DP), 32'(m_pub_p));
    chk({tag, ".stale"}, 32'(STALE), 32'(m_stale));
    fv_act.delete(); fv_exp.delete(); err_act.delete(); err_exp.delete();
  endtask

  task automatic do_reset(input int cyc);
    N_Reset = 1'b0; SEG_COM = 8'hFF; SEG_DATA = 8'h00;
    model_reset();
    repeat (cyc) @(negedge CLK);
    N_Reset = 1'b1;
    m_last = edge_cnt;
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    N_Reset = 1'b0; SEG_COM = 8'hFF; SEG_DATA = 8'h00;
    @(negedge CLK);
    do_reset(3);

    // reset values
    chk("rst.digits", DIGITS, 32'h0);
    chk("rst.blank", 32'(BLANK), 32'hFF);
    chk("rst.dp", 32'(DP), 32'h0);
    chk("rst.fv", 32'(FRAME_VALID), 32'h0);
    chk("rst.err", 32'(SEG_ERR), 32'h0);
    chk("rst.stale", 32'(STALE), 32'h1);

    // "01234567", 10-cycle slots
    for (int k = 0; k < 8; k++) scan_digit(k, k, 1'b0, 1'b0, 10, 0);
    tail();
    chk("t1.digits_const", DIGITS, 32'h76543210);
    check_all("t1");

    // digit 3 is DP-only, short glitches between slots
    for (int k = 0; k < 8; k++) scan_digit(k, k, (k == 3), (k == 3), 10, 1 + (k % (STABLE - 1)));
    tail();
    chk("t2.blank_const", 32'(BLANK), 32'h08);
    chk("t2.dp_const", 32'(DP), 32'h08);
    check_all("t2");

    // two-low select mid-frame, then a fresh full scan
    for (int k = 0; k < 3; k++) scan_digit(k, k + 8, 1'b0, 1'b0, 10, 0);
    slot(8'hFC, enc(5, 1'b0, 1'b0), 10);
    rand_scan(8);
    tail();
    check_all("t3");

    // undecodable pattern on digit 5, then a complete scan
    for (int k = 0; k < 5; k++) scan_digit(k, 15 - k, 1'b1, 1'b0, 10, 0);
    slot(~8'h20, 8'h92, 10);
    rand_scan(8);
    tail();
    check_all("t4");

    // timeout after a partial frame, then recovery
    rand_scan(4);
    slot(8'hFF, 8'h00, TMO + 5);
    chk("t5.stale_const", 32'(STALE), 32'h1);
    check_all("t5a");
    rand_scan(8);
    tail();
    chk("t5.stale_clear", 32'(STALE), 32'h0);
    check_all("t5b");

    // asynchronous reset mid-frame
    rand_scan(6);
    N_Reset = 1'b0;
    #1;
    chk("t6.async_digits", DIGITS, 32'h0);
    chk("t6.async_blank", 32'(BLANK), 32'hFF);
    chk("t6.async_stale", 32'(STALE), 32'h1);
    @(negedge CLK);
    do_reset(3);
    rand_scan(2);
    tail();
    check_all("t6");

    // randomized frames with re-captures, blanks, minimum holds and sub-threshold glitches
    for (int f = 0; f < 8; f++) begin
      rand_scan(8);
      tail();
    end
    check_all("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
